md_sched: RTL
=============

Name: md_sched

Overview:
- Sequencing controller for the multiply/divide resource fed by the E-stage md control fields.
- Accepts an operation launch from E stage, holds the HI/LO pair, and models fixed multi-cycle latency with a busy counter.
- Generates the stall request that freezes the IF/ID and ID/EX registers while an md-dependent instruction in D would conflict.
- Sits beside the ALU in E stage; the HI/LO read value returns to the E-stage result mux.

Parameters:
MUL_CYCLES, 5, busy cycles for MULT/MULTU/MADD (range 1..15)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (range 1..15)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  launch md operation this cycle (mdstartE)
op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV (mdopE)
madd  in  1  with start and op=01: accumulate signed product into {HI,LO} (isMADDE)
wr  in  1  MTHI/MTLO write (mdwriteE)
hilo_sel  in  1  1 selects HI, 0 selects LO for wr and rdata (mdHILOE)
a  in  32  rs operand, forwarded
b  in  32  rt operand, forwarded
md_use_d  in  1  instruction in D stage is MULT/DIV/MADD/MFHI/MFLO/MTHI/MTLO
busy  out  1  operation in flight
stall  out  1  freeze D, flush E bubble
hi  out  32  HI register
lo  out  32  LO register
rdata  out  32  hilo_sel ? hi : lo, combinational (MFHI/MFLO)

Behaviour:
- Reset (rst_n=0, async): state IDLE, cnt=0, hi=0, lo=0, busy=0; stall=0 once any md_use_d is low; held results discarded.
- States: IDLE, BUSY. 4-bit down counter cnt.
- IDLE with start=1: latch the 64-bit result computed from a, b, op, madd and the current {hi,lo}. Load cnt = MUL_CYCLES for op[1]=0, or DIV_CYCLES for op[1]=1. Go to BUSY.
- BUSY: cnt decrements each cycle.
  - On the edge where cnt reaches 1→0, commit the latched result to hi/lo and return to IDLE.
  - busy=1 for exactly N cycles after the start edge; hi/lo are visible in the first cycle busy=0.
- MULTU: unsigned 32x32→64, {hi,lo}=product.
- MULT: signed 32x32→64, {hi,lo}=product.
- MADD: {hi,lo} = {hi,lo} + signed product, mod 2^64. Uses hi/lo as they stand at the start edge.
- DIVU: lo = a/b, hi = a%b, unsigned.
- DIV: signed, quotient truncates toward zero, remainder takes the sign of a. 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide by zero (b=0, DIVU or DIV): lo=0xFFFFFFFF, hi=a. Normal latency.
- wr in IDLE with start=0: next edge hi (hilo_sel=1) or lo (hilo_sel=0) ← a.
- wr while BUSY is ignored; the hazard logic prevents it, and the bench asserts it never occurs.
- start and wr in the same cycle: start wins, wr dropped.
- start while BUSY: ignored, no restart; bench asserts it never occurs.
- stall = md_use_d & (start | busy), combinational. When stall=1, the pipeline holds IF/ID and clears ID/EX, so start is low next cycle.
- rdata reflects committed hi/lo only; no bypass of an in-flight result.
- Reset asserted mid-operation: in-flight result lost, hi/lo=0, IDLE immediately.

Test Plan:
- MULTU a=0xFFFFFFFF b=2 → busy high cycles 1..5 after start edge; cycle 6: hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7) b=2 → after 10 busy cycles: lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7 b=0 → lo=0xFFFFFFFF, hi=7.
- wr hilo_sel=1 a=0 then wr hilo_sel=0 a=10, then MADD a=3 b=0xFFFFFFFE (-2) → hi=0, lo=4. Then MULT 0x80000000 * 0x80000000 → hi=0x40000000, lo=0.
- Start MULT with md_use_d=1 held → stall=1 in start cycle and all 5 busy cycles, 0 in the cycle after; rdata equals the new lo once busy=0.
- Start DIV, pulse rst_n low in busy cycle 4 → busy=0, hi=lo=0 immediately; no later commit.
- start=1 and wr=1 in the same cycle (MULTU 3*4, hilo_sel=0, a=3) → lo=12, hi=0 after 5 cycles; the wr has no effect.

Source files
------------

// File: rtl/md_sched_if.sv
// Purpose : E-stage handshake bundle between the pipeline and the md_sched multiply/divide sequencer.
// Latency : pure wiring, no storage.
// Backpressure: stall (slave -> master) is the only hold-back; the master must drop start/wr while busy.
//
// Signals:
//   start, op[1:0], madd  - operation launch and selection (E stage)
//   wr, hilo_sel          - MTHI/MTLO write strobe and HI/LO select (also selects rdata)
//   a, b                  - forwarded rs/rt operands
//   md_use_d              - D-stage instruction touches the md unit
//   busy, stall           - sequencer in flight, pipeline freeze request
//   hi, lo, rdata         - committed HI/LO and the MFHI/MFLO read value
interface md_sched_if;
  logic        start;
  logic [1:0]  op;
  logic        madd;
  logic        wr;
  logic        hilo_sel;
  logic [31:0] a;
  logic [31:0] b;
  logic        md_use_d;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rdata;

  // Pipeline side: issues operations, observes status and results.
  modport master (
    output start, op, madd, wr, hilo_sel, a, b, md_use_d,
    input  busy, stall, hi, lo, rdata
  );

  // Sequencer side.
  modport slave (
    input  start, op, madd, wr, hilo_sel, a, b, md_use_d,
    output busy, stall, hi, lo, rdata
  );
endinterface

// File: rtl/md_sched.sv
// Purpose : Multiply/divide sequencer beside the E-stage ALU; owns HI/LO and models fixed md latency.
// Latency : result computed at the start edge, committed to HI/LO after MUL_CYCLES or DIV_CYCLES busy cycles.
// Backpressure: stall = md_use_d & (start | busy) freezes D and bubbles E while an md instruction would conflict.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset; drops any in-flight result and clears HI/LO
//   md     - md_sched_if.slave: start/op/madd/wr/hilo_sel/a/b/md_use_d in,
//            busy/stall/hi/lo/rdata out (rdata = hilo_sel ? hi : lo, combinational)
module md_sched #(
  parameter int unsigned MUL_CYCLES = 5,   // MULT/MULTU/MADD busy cycles, 1..15
  parameter int unsigned DIV_CYCLES = 10   // DIV/DIVU busy cycles, 1..15
) (
  input  logic      clk,
  input  logic      rst_n,
  md_sched_if.slave md
);

  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } stateT;

  stateT       state, stateNext;
  logic [3:0]  cnt, cntNext;
  logic [31:0] hiQ, hiNext;
  logic [31:0] loQ, loNext;
  logic [63:0] resQ, resNext;   // result waiting out the latency window

  // ---------------------------------------------------------------------------
  // Multiply. The low 64 bits of a 64x64 unsigned product of sign-extended
  // operands equal the signed 32x32 product, so both flavours use plain
  // unsigned multipliers.
  // ---------------------------------------------------------------------------
  logic [63:0] prodU;
  logic [63:0] prodS;

  assign prodU = {32'b0, md.a} * {32'b0, md.b};
  assign prodS = {{32{md.a[31]}}, md.a} * {{32{md.b[31]}}, md.b};

  // ---------------------------------------------------------------------------
  // Divide. One unsigned magnitude divider serves DIVU and DIV; for DIV the
  // signs are stripped first and reapplied: quotient negative when operand
  // signs differ (truncation toward zero), remainder follows the dividend.
  // 0x80000000 / -1 falls out naturally: magnitude 0x80000000, negated back
  // to 0x80000000, remainder 0.
  // ---------------------------------------------------------------------------
  logic        isSigned;
  logic        negA, negB;
  logic        divZero;
  logic [31:0] magA, magB, divisor;
  logic [31:0] quoMag, remMag;
  logic [31:0] quo, rem;

  assign isSigned = md.op[0];
  assign negA     = isSigned & md.a[31];
  assign negB     = isSigned & md.b[31];
  assign magA     = negA ? (32'd0 - md.a) : md.a;
  assign magB     = negB ? (32'd0 - md.b) : md.b;
  assign divZero  = (md.b == 32'd0);
  // Keep the divider away from a zero divisor; that case is muxed out below.
  assign divisor  = divZero ? 32'd1 : magB;
  assign quoMag   = magA / divisor;
  assign remMag   = magA % divisor;
  assign quo      = (negA ^ negB) ? (32'd0 - quoMag) : quoMag;
  assign rem      = negA ? (32'd0 - remMag) : remMag;

  // ---------------------------------------------------------------------------
  // Result select, {hi, lo}.
  // ---------------------------------------------------------------------------
  logic [63:0] result;

  always_comb begin
    result = 64'd0;
    unique case (md.op)
      2'b00: result = prodU;
      // MADD accumulates onto HI/LO as they stand at the start edge.
      2'b01: result = md.madd ? ({hiQ, loQ} + prodS) : prodS;
      // Divide by zero: quotient all ones, remainder is the dividend.
      2'b10,
      2'b11: result = divZero ? {md.a, 32'hFFFF_FFFF} : {rem, quo};
      default: result = 64'd0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequencer.
  // ---------------------------------------------------------------------------
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    resNext   = resQ;
    hiNext    = hiQ;
    loNext    = loQ;
    unique case (state)
      IDLE: begin
        // start has priority; a same-cycle wr is dropped.
        if (md.start) begin
          resNext   = result;
          cntNext   = md.op[1] ? DIV_LOAD : MUL_LOAD;
          stateNext = BUSY;
        end else if (md.wr) begin
          if (md.hilo_sel) hiNext = md.a;
          else             loNext = md.a;
        end
      end
      BUSY: begin
        // start and wr are ignored here; the hazard logic keeps them away.
        // The <= guard keeps an out-of-range zero load from hanging in BUSY.
        if (cnt <= 4'd1) begin
          cntNext   = 4'd0;
          {hiNext, loNext} = resQ;
          stateNext = IDLE;
        end else begin
          cntNext = cnt - 4'd1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      resQ  <= 64'd0;
      hiQ   <= 32'd0;
      loQ   <= 32'd0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      resQ  <= resNext;
      hiQ   <= hiNext;
      loQ   <= loNext;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. rdata shows committed HI/LO only; no bypass of the pending result.
  // ---------------------------------------------------------------------------
  assign md.busy  = (state == BUSY);
  assign md.stall = md.md_use_d & (md.start | md.busy);
  assign md.hi    = hiQ;
  assign md.lo    = loQ;
  assign md.rdata = md.hilo_sel ? hiQ : loQ;

endmodule
